imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter HALT_WORD, default 32'hFFFF_FFFF: the word value that ends a load.
REQ-002 SHALL provide parameter MAX_WORDS, default 64: the instruction memory capacity in 32-bit words.
REQ-003 SHALL provide port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port start, input, 1 bit: a one-cycle pulse that begins a program load at address 0.
REQ-006 SHALL provide port rx_data, input, 8 bits: an incoming program byte, sent little-endian within each word.
REQ-007 SHALL provide port rx_valid, input, 1 bit: a one-cycle strobe marking rx_data valid.
REQ-008 SHALL provide port mem_wr_en, output, 1 bit: the instruction memory write enable.
REQ-009 SHALL provide port mem_wr_addr, output, 8 bits: the byte address of the word being written, always a multiple of 4.
REQ-010 SHALL provide port mem_wr_data, output, 32 bits: the assembled word.
REQ-011 SHALL provide port mem_rd_en, output, 1 bit: the fetch read enable for instruction memory.
REQ-012 SHALL provide port cpu_stall, output, 1 bit: holds the pipeline (PC and IF) frozen while loading.
REQ-013 SHALL provide port busy, output, 1 bit: high while a load is in progress.
REQ-014 SHALL provide port load_done, output, 1 bit: a sticky flag that the last load completed.
REQ-015 SHALL provide port word_count, output, 7 bits: the number of words written in the current or last load.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-017 IDLE and DONE SHALL drive mem_rd_en=1, cpu_stall=0 and busy=0; rx_valid SHALL be ignored in these states.
REQ-018 In IDLE or DONE, start SHALL move the block to RECV, with mem_wr_addr=0, word_count=0, byte index=0 and load_done=0.
REQ-019 RECV and WRITE SHALL drive mem_rd_en=0, cpu_stall=1 and busy=1.
REQ-020 In RECV, each rx_valid SHALL store rx_data into bits [8*i+7:8*i] of the word buffer, where i is the byte index (0..3), and SHALL then increment i.
REQ-021 On the 4th byte (i=3 with rx_valid), the complete word SHALL be registered into mem_wr_data, i SHALL return to 0, and the block SHALL enter WRITE on the next cycle.
REQ-022 WRITE SHALL last exactly one cycle, with mem_wr_en=1 and mem_wr_addr/mem_wr_data stable; mem_wr_en SHALL be 0 in every other state.
REQ-023 On leaving WRITE, mem_wr_addr SHALL advance by 4 (8-bit, wrapping modulo 256) and word_count SHALL advance by 1.
REQ-024 WRITE SHALL go to DONE if mem_wr_data == HALT_WORD or the incremented word_count == MAX_WORDS, and SHALL go to RECV otherwise.
REQ-025 The halt word SHALL itself be written to memory.
REQ-026 load_done SHALL be set on the WRITE-to-DONE transition and held until the next start or reset.
REQ-027 An rx_valid during WRITE SHALL be stored as byte 0 of the next word (i becomes 1) when the next state is RECV, and SHALL be discarded when the next state is DONE.
REQ-028 A start in RECV SHALL abort the partial word: i=0, mem_wr_addr=0, word_count=0, state stays RECV, and any simultaneous rx_valid byte is discarded.
REQ-029 A start in WRITE SHALL be ignored; the write always completes.
REQ-030 All outputs SHALL be registered or decoded from the state register, with no combinational path from rx_* to mem_wr_en.

Reset
REQ-031 While reset is asserted, the block SHALL hold state=IDLE, i=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, word_count=0, load_done=0, busy=0, cpu_stall=0 and mem_rd_en=1.
REQ-032 A reset asserted mid-load SHALL abandon the load immediately with no further write; words already written are not recalled.
REQ-033 After reset deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-034 Basic load: start; bytes 13,00,00,00 | FF,FF,FF,FF -> writes 32'h0000_0013 @0x00, then 32'hFFFF_FFFF @0x04; load_done=1; word_count=2; mem_rd_en=1.
REQ-035 Capacity: start; 64 non-halt words -> 64 one-cycle writes at 0x00..0xFC; DONE after the 64th; a 65th word's bytes are ignored; word_count=64.
REQ-036 Back-to-back: 4th byte followed by a byte in the WRITE cycle -> that byte lands in bits [7:0] of the next word, with no loss.
REQ-037 Abort: start, bytes AA,BB, then start -> no write issued; the next 4 bytes 01,02,03,04 are written as 32'h0403_0201 @0x00.
REQ-038 Reset mid-load: assert reset in the RECV state after 2 words -> all outputs go to reset values asynchronously; no mem_wr_en pulse occurs; a new start writes again from 0x00.
REQ-039 Gating: during the whole load cpu_stall=1 and mem_rd_en=0; both return to 0/1 in the cycle DONE is entered; rx_valid in IDLE or DONE causes no write.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles little-endian bytes into 32-bit words
// and writes them to IMEM while holding the CPU fetch stage stalled.
module imem_loader #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_rd_en,
    output logic        cpu_stall,
    output logic        busy,
    output logic        load_done,
    output logic [6:0]  word_count
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [6:0] MAX_W = 7'(MAX_WORDS);

    state_t      state, next_state;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [6:0]  count_inc;
    logic        last_word;

    assign count_inc = word_count + 7'd1;
    assign last_word = (mem_wr_data == HALT_WORD) || (count_inc == MAX_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Outputs decode from the state register only, so rx_* never reaches mem_wr_en.
    always_comb begin
        next_state = state;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b1;
        cpu_stall  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = RECV;
            end
            RECV: begin
                mem_rd_en = 1'b0;
                cpu_stall = 1'b1;
                busy      = 1'b1;
                if (!start && rx_valid && byte_idx == 2'd3) next_state = WRITE;
            end
            WRITE: begin
                mem_wr_en  = 1'b1;
                mem_rd_en  = 1'b0;
                cpu_stall  = 1'b1;
                busy       = 1'b1;
                next_state = last_word ? DONE : RECV;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx    <= 2'd0;
            word_buf    <= 24'd0;
            mem_wr_addr <= 8'd0;
            mem_wr_data <= 32'd0;
            word_count  <= 7'd0;
            load_done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx    <= 2'd0;
                        mem_wr_addr <= 8'd0;
                        word_count  <= 7'd0;
                        load_done   <= 1'b0;
                    end
                end
                RECV: begin
                    // A restart drops the partial word and any byte arriving with it.
                    if (start) begin
                        byte_idx    <= 2'd0;
                        mem_wr_addr <= 8'd0;
                        word_count  <= 7'd0;
                    end else if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0:    word_buf[7:0]   <= rx_data;
                            2'd1:    word_buf[15:8]  <= rx_data;
                            2'd2:    word_buf[23:16] <= rx_data;
                            default: mem_wr_data     <= {rx_data, word_buf};
                        endcase
                    end
                end
                WRITE: begin
                    mem_wr_addr <= mem_wr_addr + 8'd4;
                    word_count  <= count_inc;
                    if (last_word) begin
                        load_done <= 1'b1;
                    end else if (rx_valid) begin
                        // Byte arriving during the write cycle opens the next word.
                        word_buf[7:0] <= rx_data;
                        byte_idx      <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: load, capacity, back-to-back, abort,
// reset mid-load and fetch gating scenarios.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_wr_en;
    logic [7:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic        cpu_stall;
    logic        busy;
    logic        load_done;
    logic [6:0]  word_count;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  stim[$];
    int          wr_pulses = 0;

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .cpu_stall(cpu_stall), .busy(busy),
        .load_done(load_done), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wa_q.push_back(mem_wr_addr);
            wd_q.push_back(mem_wr_data);
            wr_pulses++;
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stim.push_back(w[8*b +: 8]);
    endtask

    // gap=1 leaves an idle cycle after each byte; gap=0 streams one byte per cycle.
    task automatic send_stim(input bit gap);
        foreach (stim[k]) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stim[k];
            if (gap) begin
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        stim.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        #1;
        tests++; if (mem_wr_en !== 1'b0)    begin failed++; $display("FAIL reset_wr_en got %b want 0", mem_wr_en); end
        tests++; if (mem_wr_addr !== 8'h00) begin failed++; $display("FAIL reset_addr got %h want 00", mem_wr_addr); end
        tests++; if (mem_wr_data !== 32'h0) begin failed++; $display("FAIL reset_data got %h want 0", mem_wr_data); end
        tests++; if (word_count !== 7'd0)   begin failed++; $display("FAIL reset_count got %0d want 0", word_count); end
        tests++; if (load_done !== 1'b0)    begin failed++; $display("FAIL reset_done got %b want 0", load_done); end
        tests++; if (busy !== 1'b0)         begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (cpu_stall !== 1'b0)    begin failed++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        tests++; if (mem_rd_en !== 1'b1)    begin failed++; $display("FAIL reset_rd_en got %b want 1", mem_rd_en); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin failed++; $display("FAIL idle_hold busy got %b want 0", busy); end
        tests++; if (wr_pulses !== 0) begin failed++; $display("FAIL idle_hold writes got %0d want 0", wr_pulses); end
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start();
        tests++; if (busy !== 1'b1)      begin failed++; $display("FAIL basic_busy got %b want 1", busy); end
        tests++; if (cpu_stall !== 1'b1) begin failed++; $display("FAIL basic_stall got %b want 1", cpu_stall); end
        tests++; if (mem_rd_en !== 1'b0) begin failed++; $display("FAIL basic_rd_en got %b want 0", mem_rd_en); end
        push_word(32'h0000_0013);
        push_word(32'hFFFF_FFFF);
        send_stim(1'b1);
        // Now in the first cycle of DONE.
        tests++; if (mem_rd_en !== 1'b1)  begin failed++; $display("FAIL basic_done_rd_en got %b want 1", mem_rd_en); end
        tests++; if (cpu_stall !== 1'b0)  begin failed++; $display("FAIL basic_done_stall got %b want 0", cpu_stall); end
        tests++; if (busy !== 1'b0)       begin failed++; $display("FAIL basic_done_busy got %b want 0", busy); end
        tests++; if (load_done !== 1'b1)  begin failed++; $display("FAIL basic_load_done got %b want 1", load_done); end
        tests++; if (word_count !== 7'd2) begin failed++; $display("FAIL basic_count got %0d want 2", word_count); end
        tests++; if (wa_q.size() !== 2)   begin failed++; $display("FAIL basic_nwrites got %0d want 2", wa_q.size()); end
        tests++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h0000_0013)
            begin failed++; $display("FAIL basic_w0 got %h@%h want 00000013@00", wd_q[0], wa_q[0]); end
        tests++; if (wa_q[1] !== 8'h04 || wd_q[1] !== 32'hFFFF_FFFF)
            begin failed++; $display("FAIL basic_w1 got %h@%h want ffffffff@04", wd_q[1], wa_q[1]); end
    endtask

    task automatic test_done_ignore();
        int n = wr_pulses;
        push_word(32'h0403_0201);
        push_word(32'h0807_0605);
        send_stim(1'b0);
        repeat (2) @(negedge clk);
        tests++; if (wr_pulses !== n)     begin failed++; $display("FAIL done_ignore writes got %0d want %0d", wr_pulses, n); end
        tests++; if (word_count !== 7'd2) begin failed++; $display("FAIL done_ignore count got %0d want 2", word_count); end
        tests++; if (load_done !== 1'b1)  begin failed++; $display("FAIL done_ignore done got %b want 1", load_done); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        pulse_start();
        tests++; if (load_done !== 1'b0) begin failed++; $display("FAIL b2b_done_clr got %b want 0", load_done); end
        push_word(32'h4433_2211);
        push_word(32'h8877_6655);
        push_word(32'hFFFF_FFFF);
        send_stim(1'b0);
        repeat (3) @(negedge clk);
        tests++; if (wa_q.size() !== 3) begin failed++; $display("FAIL b2b_nwrites got %0d want 3", wa_q.size()); end
        tests++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h4433_2211)
            begin failed++; $display("FAIL b2b_w0 got %h@%h want 44332211@00", wd_q[0], wa_q[0]); end
        tests++; if (wa_q[1] !== 8'h04 || wd_q[1] !== 32'h8877_6655)
            begin failed++; $display("FAIL b2b_w1 got %h@%h want 88776655@04", wd_q[1], wa_q[1]); end
        tests++; if (wa_q[2] !== 8'h08 || wd_q[2] !== 32'hFFFF_FFFF)
            begin failed++; $display("FAIL b2b_w2 got %h@%h want ffffffff@08", wd_q[2], wa_q[2]); end
        tests++; if (word_count !== 7'd3) begin failed++; $display("FAIL b2b_count got %0d want 3", word_count); end
    endtask

    task automatic test_abort();
        clear_log();
        pulse_start();
        stim.push_back(8'hAA);
        stim.push_back(8'hBB);
        send_stim(1'b1);
        // Restart with a simultaneous byte that must be dropped.
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        tests++; if (wa_q.size() !== 0)   begin failed++; $display("FAIL abort_nowrite got %0d want 0", wa_q.size()); end
        tests++; if (busy !== 1'b1)       begin failed++; $display("FAIL abort_busy got %b want 1", busy); end
        tests++; if (word_count !== 7'd0) begin failed++; $display("FAIL abort_count got %0d want 0", word_count); end
        push_word(32'h0403_0201);
        push_word(32'hFFFF_FFFF);
        send_stim(1'b1);
        tests++; if (wa_q.size() !== 2) begin failed++; $display("FAIL abort_nwrites got %0d want 2", wa_q.size()); end
        tests++; if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h0403_0201)
            begin failed++; $display("FAIL abort_w0 got %h@%h want 04030201@00", wd_q[0], wa_q[0]); end
        tests++; if (wa_q[1] !== 8'h04 || wd_q[1] !== 32'hFFFF_FFFF)
            begin failed++; $display("FAIL abort_w1 got %h@%h want ffffffff@04", wd_q[1], wa_q[1]); end
    endtask

    task automatic test_capacity();
        int bad = 0;
        clear_log();
        pulse_start();
        for (int w = 0; w < 65; w++) push_word(32'h1000_0000 + 32'(w));
        send_stim(1'b0);
        repeat (3) @(negedge clk);
        tests++; if (wa_q.size() !== 64) begin failed++; $display("FAIL cap_nwrites got %0d want 64", wa_q.size()); end
        for (int w = 0; w < 64; w++) begin
            tests++;
            if (wa_q[w] !== 8'(4 * w) || wd_q[w] !== 32'h1000_0000 + 32'(w)) begin
                failed++;
                if (bad < 4) $display("FAIL cap_w%0d got %h@%h want %h@%h",
                                      w, wd_q[w], wa_q[w], 32'h1000_0000 + 32'(w), 8'(4 * w));
                bad++;
            end
        end
        tests++; if (word_count !== 7'd64) begin failed++; $display("FAIL cap_count got %0d want 64", word_count); end
        tests++; if (load_done !== 1'b1)   begin failed++; $display("FAIL cap_done got %b want 1", load_done); end
        tests++; if (mem_rd_en !== 1'b1)   begin failed++; $display("FAIL cap_rd_en got %b want 1", mem_rd_en); end
    endtask

    task automatic test_reset_mid_load();
        int n;
        clear_log();
        pulse_start();
        push_word(32'hA0A1_A2A3);
        push_word(32'hB0B1_B2B3);
        stim.push_back(8'hC0);
        stim.push_back(8'hC1);
        send_stim(1'b1);
        n = wr_pulses;
        tests++; if (busy !== 1'b1) begin failed++; $display("FAIL rst_mid_prebusy got %b want 1", busy); end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || cpu_stall !== 1'b0 || mem_rd_en !== 1'b1)
            begin failed++; $display("FAIL rst_mid_gating got busy=%b stall=%b rd=%b want 0 0 1", busy, cpu_stall, mem_rd_en); end
        tests++; if (mem_wr_addr !== 8'h00 || mem_wr_data !== 32'h0 || word_count !== 7'd0)
            begin failed++; $display("FAIL rst_mid_regs got %h %h %0d want 00 0 0", mem_wr_addr, mem_wr_data, word_count); end
        tests++; if (load_done !== 1'b0) begin failed++; $display("FAIL rst_mid_done got %b want 0", load_done); end
        stim.push_back(8'hC2);
        stim.push_back(8'hC3);
        send_stim(1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (wr_pulses !== n) begin failed++; $display("FAIL rst_mid_nowrite got %0d want %0d", wr_pulses, n); end
        tests++; if (busy !== 1'b0)   begin failed++; $display("FAIL rst_mid_idle got %b want 0", busy); end
        pulse_start();
        push_word(32'hD3D2_D1D0);
        push_word(32'hFFFF_FFFF);
        send_stim(1'b1);
        tests++; if (wa_q.size() !== 4) begin failed++; $display("FAIL rst_mid_nwrites got %0d want 4", wa_q.size()); end
        tests++; if (wa_q[2] !== 8'h00 || wd_q[2] !== 32'hD3D2_D1D0)
            begin failed++; $display("FAIL rst_mid_w0 got %h@%h want d3d2d1d0@00", wd_q[2], wa_q[2]); end
        tests++; if (wa_q[3] !== 8'h04 || word_count !== 7'd2)
            begin failed++; $display("FAIL rst_mid_w1 got addr %h count %0d want 04 2", wa_q[3], word_count); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        test_reset();
        test_basic_load();
        test_done_ignore();
        test_back_to_back();
        test_abort();
        test_capacity();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
